// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// The optional parity bit is enabled with the FIFO_UART_TX_PARITY_EN macro.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } state_t;

  localparam int DATA_W_DEF = 8;

  localparam logic TX_IDLE  = 1'b1;
  localparam logic TX_START = 1'b0;

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while not cleared and flags the
// last cycle (bit_tick) and the one before it (pre_tick) of every bit.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick,
  output logic pre_tick
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bit_tick = !clear && (r_cnt == LAST);
  assign pre_tick = !clear && (r_cnt == PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the upstream FIFO and sends them as LSB-first UART frames.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit before the stop bits.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              buf_empty,
  input  logic [DATA_W-1:0] buf_out,
  output logic              rd_en,
  output logic              tx,
  output logic              busy,
  output logic              tx_done,
  output state_t            dbg_state
);

  localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

  state_t            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [BCW-1:0]    r_bit_cnt;
  logic              r_stop_cnt;
  logic              r_tx;
  logic              r_rd_en;
  logic              r_busy;
  logic              r_tx_done;
`ifdef FIFO_UART_TX_PARITY_EN
  logic              r_parity;
`endif

  logic              w_clear;
  logic              w_bit_tick;
  logic              w_pre_tick;
  logic              w_last_stop;
  logic [DATA_W-1:0] w_shift_next;

  // Baud timer is held at zero until the frame starts, so START gets a full bit.
  assign w_clear      = (r_state == ST_IDLE) || (r_state == ST_FETCH) || (r_state == ST_LOAD);
  assign w_last_stop  = (STOP_BITS == 1) || r_stop_cnt;
  assign w_shift_next = r_shift >> 1;

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clear    (w_clear),
    .bit_tick (w_bit_tick),
    .pre_tick (w_pre_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_tx       <= TX_IDLE;
      r_rd_en    <= 1'b0;
      r_busy     <= 1'b0;
      r_tx_done  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_rd_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (enable && !buf_empty) begin
            r_state <= ST_FETCH;
            r_rd_en <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_FETCH: r_state <= ST_LOAD;
        ST_LOAD: begin
          r_shift <= buf_out;
`ifdef FIFO_UART_TX_PARITY_EN
          r_parity <= ^buf_out;
`endif
          r_tx    <= TX_START;
          r_state <= ST_START;
        end
        ST_START: begin
          if (w_bit_tick) begin
            r_state   <= ST_DATA;
            r_tx      <= r_shift[0];
            r_bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (w_bit_tick) begin
            r_shift <= w_shift_next;
            if (r_bit_cnt == LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
              r_state <= ST_PARITY;
              r_tx    <= r_parity;
`else
              r_state    <= ST_STOP;
              r_tx       <= TX_IDLE;
              r_stop_cnt <= 1'b0;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_tx      <= w_shift_next[0];
            end
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        ST_PARITY: begin
          if (w_bit_tick) begin
            r_state    <= ST_STOP;
            r_tx       <= TX_IDLE;
            r_stop_cnt <= 1'b0;
          end
        end
`endif
        ST_STOP: begin
          // tx_done is registered, so it is raised one cycle ahead of the last stop cycle.
          if (w_pre_tick && w_last_stop) r_tx_done <= 1'b1;
          if (w_bit_tick) begin
            if (w_last_stop) begin
              r_state   <= ST_IDLE;
              r_busy    <= 1'b0;
              r_tx_done <= 1'b0;
            end else begin
              r_stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= TX_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_en     = r_rd_en;
  assign tx        = r_tx;
  assign busy      = r_busy;
  assign tx_done   = r_tx_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a behavioural FIFO and per-bit frame checks.
// Build with FIFO_UART_TX_PARITY_EN defined to also expect the parity bit.
module tb_fifo_uart_tx;
  import fifo_uart_pkg::*;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       buf_empty = 1'b1;
  logic [7:0] buf_out = 8'h5A;
  logic       rd_en, tx, busy, tx_done;
  state_t     dbg_state;

  logic [7:0] fifo_q[$];
  logic       pend = 1'b0;
  int         underflow = 0;
  int         rd_cnt = 0, done_cnt = 0, busy_cnt = 0;
  int         n_cmp = 0, n_err = 0;

  fifo_uart_tx #(.CLKS_PER_BIT(C), .DATA_W(8), .STOP_BITS(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .buf_empty (buf_empty),
    .buf_out   (buf_out),
    .rd_en     (rd_en),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // FIFO model: data appears during the cycle after the pop strobe, junk otherwise.
  always @(negedge clk) begin
    if (pend) begin
      if (fifo_q.size() == 0) begin
        underflow = underflow + 1;
        buf_out = 8'h5A;
      end else begin
        buf_out = fifo_q.pop_front();
      end
    end else begin
      buf_out = 8'h5A;
    end
    pend = rd_en;
    buf_empty = (fifo_q.size() == 0);
  end

  always @(negedge clk) begin
    if (rd_en === 1'b1) rd_cnt = rd_cnt + 1;
    if (tx_done === 1'b1) done_cnt = done_cnt + 1;
    if (busy === 1'b1) busy_cnt = busy_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic sample_bit(output logic [31:0] txv, output logic [31:0] donev);
    txv = '0;
    donev = '0;
    for (int j = 0; j < C; j++) begin
      @(negedge clk);
      txv[j] = tx;
      donev[j] = tx_done;
    end
  endtask

  // Waits for the pop strobe, then checks the frame bit by bit; n = cycles waited.
  task automatic run_frame(input logic [7:0] b, input int drop_bit, output int n);
    logic [31:0] txv, dv, allc;
    allc = (32'h1 << C) - 1;
    n = 0;
    while (rd_en !== 1'b1 && n < 200) begin
      @(negedge clk);
      n = n + 1;
    end
    check_val("fetch_rd_en", {31'b0, rd_en}, 32'h1);
    check_val("fetch_tx_busy", {30'b0, tx, busy}, 32'h3);
    @(negedge clk);
    check_val("load_tx_rd_busy", {29'b0, tx, rd_en, busy}, 32'h5);
    sample_bit(txv, dv);
    check_val("start_bit", txv, 32'h0);
    for (int i = 0; i < 8; i++) begin
      if (i == drop_bit) enable = 1'b0;
      sample_bit(txv, dv);
      check_val($sformatf("data_bit%0d", i), txv, b[i] ? allc : 32'h0);
    end
`ifdef FIFO_UART_TX_PARITY_EN
    sample_bit(txv, dv);
    check_val("parity_bit", txv, (^b) ? allc : 32'h0);
`endif
    sample_bit(txv, dv);
    check_val("stop_bit", txv, allc);
    check_val("tx_done_pos", dv, 32'h1 << (C - 1));
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) @(negedge clk);
  endtask

  initial begin
    int n, rd0, dn0, bz0, bad;
    rst = 1'b1;
    enable = 1'b0;
    idle_cycles(3);
    rst = 1'b0;
    check_val("reset_outputs", {28'b0, tx, busy, rd_en, tx_done}, 32'h8);
    check_val("reset_state", 32'(dbg_state), 32'(ST_IDLE));

    // Single frame 0xA5
    rd0 = rd_cnt; dn0 = done_cnt; bz0 = busy_cnt;
    fifo_q.push_back(8'hA5);
    enable = 1'b1;
    run_frame(8'hA5, -1, n);
    idle_cycles(10);
    check_val("a5_rd_pulses", 32'(rd_cnt - rd0), 32'd1);
    check_val("a5_done_pulses", 32'(done_cnt - dn0), 32'd1);
`ifdef FIFO_UART_TX_PARITY_EN
    check_val("a5_busy_cycles", 32'(busy_cnt - bz0), 32'd46);
`else
    check_val("a5_busy_cycles", 32'(busy_cnt - bz0), 32'd42);
`endif

    // Back-to-back 0x3C, 0xC3
    enable = 1'b0;
    rd0 = rd_cnt;
    fifo_q.push_back(8'h3C);
    fifo_q.push_back(8'hC3);
    idle_cycles(2);
    enable = 1'b1;
    run_frame(8'h3C, -1, n);
    run_frame(8'hC3, -1, n);
    check_val("b2b_gap_wait", 32'(n), 32'd2);
    enable = 1'b0;
    idle_cycles(5);
    check_val("b2b_rd_pulses", 32'(rd_cnt - rd0), 32'd2);

    // Empty FIFO with enable high
    enable = 1'b1;
    rd0 = rd_cnt;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad = bad + 1;
    end
    check_val("empty_rd_pulses", 32'(rd_cnt - rd0), 32'd0);
    check_val("empty_idle_bad", 32'(bad), 32'd0);

    // Enable dropped mid-data of 0x55
    rd0 = rd_cnt; dn0 = done_cnt;
    fifo_q.push_back(8'h55);
    fifo_q.push_back(8'hAA);
    fifo_q.push_back(8'h0F);
    run_frame(8'h55, 3, n);
    idle_cycles(20);
    check_val("drop_rd_pulses", 32'(rd_cnt - rd0), 32'd1);
    check_val("drop_done_pulses", 32'(done_cnt - dn0), 32'd1);
    check_val("drop_fifo_count", 32'(fifo_q.size()), 32'd2);

    // Reset mid-data: 0xAA is lost, 0x0F follows
    enable = 1'b1;
    n = 0;
    while (rd_en !== 1'b1 && n < 50) begin
      @(negedge clk);
      n = n + 1;
    end
    check_val("pre_rst_fetch", {31'b0, rd_en}, 32'h1);
    idle_cycles(13);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("rst_outputs", {28'b0, tx, busy, rd_en, tx_done}, 32'h8);
    check_val("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    run_frame(8'h0F, -1, n);
    check_val("restart_fetch_wait", 32'(n), 32'd1);
    enable = 1'b0;
    idle_cycles(5);
    check_val("rst_fifo_count", 32'(fifo_q.size()), 32'd0);

    // Odd and even parity bytes
    fifo_q.push_back(8'h07);
    fifo_q.push_back(8'hA5);
    idle_cycles(2);
    enable = 1'b1;
    run_frame(8'h07, -1, n);
    run_frame(8'hA5, -1, n);
    check_val("par_gap_wait", 32'(n), 32'd2);
    enable = 1'b0;
    idle_cycles(5);
    check_val("final_idle", {30'b0, tx, busy}, 32'h2);
    check_val("no_underflow", 32'(underflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
